sad_window_engine: RTL and testbench

Sequential sum-of-absolute-differences engine for the block-matching datapath. It sits directly downstream of the data memory's window port and consumes the sixteen window words V1..V16. An `Init` load captures them as the 4x4 reference template. Each later `Start` snapshots the current candidate window and accumulates its SAD one row per cycle. It also tracks the minimum SAD seen and the address that produced it.

---
 rtl/sad_window_engine.sv | 185 ++++++++++++++++++
 tb/tb_sad_window_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_window_engine.sv
// sad_window_engine: 4x4 sum-of-absolute-differences engine, one row per cycle, with min/argmin tracking.
// Define SAD_EARLY_TERMINATE_EN to abandon windows that can no longer beat the current minimum.
module sad_window_engine #(
    parameter int PIX_W = 8,
    parameter int SAD_W = PIX_W + 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Start,
    input  logic             ClearMin,
    input  logic [31:0]      Address,
    input  logic [31:0]      V1,
    input  logic [31:0]      V2,
    input  logic [31:0]      V3,
    input  logic [31:0]      V4,
    input  logic [31:0]      V5,
    input  logic [31:0]      V6,
    input  logic [31:0]      V7,
    input  logic [31:0]      V8,
    input  logic [31:0]      V9,
    input  logic [31:0]      V10,
    input  logic [31:0]      V11,
    input  logic [31:0]      V12,
    input  logic [31:0]      V13,
    input  logic [31:0]      V14,
    input  logic [31:0]      V15,
    input  logic [31:0]      V16,
    output logic             Busy,
    output logic             Done,
    output logic             Pruned,
    output logic [SAD_W-1:0] SadValue,
    output logic [SAD_W-1:0] MinSad,
    output logic [31:0]      MinAddress,
    output logic             BestValid
);
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [SAD_W-1:0] acc_q, acc_d, sad_q, sad_d, min_q, min_d;
    logic [31:0]      addr_q, addr_d, min_addr_q, min_addr_d;
    logic             done_q, done_d, pruned_q, pruned_d, best_valid_q, best_valid_d;
    logic [PIX_W-1:0] t_q [16];
    logic [PIX_W-1:0] t_d [16];
    logic [PIX_W-1:0] w_q [16];
    logic [PIX_W-1:0] w_d [16];
    logic [31:0]      v_word [16];
    logic [PIX_W-1:0] v_pix [16];
    logic [PIX_W-1:0] col_diff [4];
    logic [SAD_W-1:0] row_sum, acc_next;
    logic             prune_hit, last_row;

    assign v_word[0]  = V1;   assign v_word[1]  = V2;   assign v_word[2]  = V3;   assign v_word[3]  = V4;
    assign v_word[4]  = V5;   assign v_word[5]  = V6;   assign v_word[6]  = V7;   assign v_word[7]  = V8;
    assign v_word[8]  = V9;   assign v_word[9]  = V10;  assign v_word[10] = V11;  assign v_word[11] = V12;
    assign v_word[12] = V13;  assign v_word[13] = V14;  assign v_word[14] = V15;  assign v_word[15] = V16;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pix
            logic unused_hi;
            assign v_pix[gi]  = v_word[gi][PIX_W-1:0];
            assign unused_hi  = ^v_word[gi][31:PIX_W];
        end
        // One absolute difference per column of the row being accumulated.
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [PIX_W-1:0] w_pix, t_pix;
            assign w_pix        = w_q[{row_q, 2'(gi)}];
            assign t_pix        = t_q[{row_q, 2'(gi)}];
            assign col_diff[gi] = (w_pix >= t_pix) ? (w_pix - t_pix) : (t_pix - w_pix);
        end
    endgenerate

    always_comb begin
        row_sum = '0;
        for (int c = 0; c < 4; c++) begin
            row_sum = row_sum + {{(SAD_W-PIX_W){1'b0}}, col_diff[c]};
        end
    end

    assign acc_next = acc_q + row_sum;

`ifdef SAD_EARLY_TERMINATE_EN
    assign prune_hit = (row_q != 2'd3) && best_valid_q && (acc_next >= min_q);
`else
    assign prune_hit = 1'b0;
`endif

    assign last_row = (state_q == ACCUM) && ((row_q == 2'd3) || prune_hit);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!Init && Start) state_d = ACCUM;
            ACCUM:   if (last_row)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        t_d          = t_q;
        w_d          = w_q;
        row_d        = row_q;
        acc_d        = acc_q;
        addr_d       = addr_q;
        sad_d        = sad_q;
        min_d        = min_q;
        min_addr_d   = min_addr_q;
        done_d       = 1'b0;
        pruned_d     = 1'b0;
        best_valid_d = best_valid_q;
        if (state_q == IDLE) begin
            if (Init) begin
                t_d = v_pix;
            end else if (Start) begin
                w_d    = v_pix;
                addr_d = Address;
                acc_d  = '0;
                row_d  = '0;
            end
        end else begin
            acc_d = acc_next;
            row_d = row_q + 2'd1;
            if (last_row) begin
                row_d    = '0;
                sad_d    = acc_next;
                done_d   = 1'b1;
                pruned_d = prune_hit;
                // Strict less-than: ties keep the earlier window; a coincident clear discards the result.
                if (!prune_hit && !ClearMin && (!best_valid_q || acc_next < min_q)) begin
                    min_d        = acc_next;
                    min_addr_d   = addr_q;
                    best_valid_d = 1'b1;
                end
            end
        end
        if (ClearMin) best_valid_d = 1'b0;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) begin
                t_q[i] <= '0;
                w_q[i] <= '0;
            end
            row_q        <= '0;
            acc_q        <= '0;
            addr_q       <= '0;
            sad_q        <= '0;
            min_q        <= '0;
            min_addr_q   <= '0;
            done_q       <= 1'b0;
            pruned_q     <= 1'b0;
            best_valid_q <= 1'b0;
        end else begin
            t_q          <= t_d;
            w_q          <= w_d;
            row_q        <= row_d;
            acc_q        <= acc_d;
            addr_q       <= addr_d;
            sad_q        <= sad_d;
            min_q        <= min_d;
            min_addr_q   <= min_addr_d;
            done_q       <= done_d;
            pruned_q     <= pruned_d;
            best_valid_q <= best_valid_d;
        end
    end

    always_comb begin
        Busy       = (state_q == ACCUM);
        Done       = done_q;
        Pruned     = pruned_q;
        SadValue   = sad_q;
        MinSad     = min_q;
        MinAddress = min_addr_q;
        BestValid  = best_valid_q;
    end
endmodule

// File: tb/tb_sad_window_engine.sv
// tb_sad_window_engine: directed plus randomized checks of sad_window_engine against a
// window-level reference model; honours SAD_EARLY_TERMINATE_EN like the design.
module tb_sad_window_engine;
    localparam int PIX_W = 8;
    localparam int SAD_W = 12;
`ifdef SAD_EARLY_TERMINATE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Init = 1'b0;
    logic             Start = 1'b0;
    logic             ClearMin = 1'b0;
    logic [31:0]      Address = '0;
    logic [31:0]      v [16];
    logic             Busy, Done, Pruned, BestValid;
    logic [SAD_W-1:0] SadValue, MinSad;
    logic [31:0]      MinAddress;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    sad_window_engine #(.PIX_W(PIX_W), .SAD_W(SAD_W)) dut (
        .Clk(Clk), .Reset(Reset), .Init(Init), .Start(Start), .ClearMin(ClearMin),
        .Address(Address),
        .V1(v[0]),   .V2(v[1]),   .V3(v[2]),   .V4(v[3]),
        .V5(v[4]),   .V6(v[5]),   .V7(v[6]),   .V8(v[7]),
        .V9(v[8]),   .V10(v[9]),  .V11(v[10]), .V12(v[11]),
        .V13(v[12]), .V14(v[13]), .V15(v[14]), .V16(v[15]),
        .Busy(Busy), .Done(Done), .Pruned(Pruned), .SadValue(SadValue),
        .MinSad(MinSad), .MinAddress(MinAddress), .BestValid(BestValid)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: whole-window arithmetic, a job counter and the min/argmin rules.
    int          m_t [16];
    int          m_w [16];
    int          m_rows;
    int          m_part;
    bit          m_prune;
    logic [31:0] m_addr;
    bit          e_busy, e_done, e_pruned, e_valid;
    int          e_sad, e_min;
    logic [31:0] e_maddr;

    function automatic int part_sum(int rows);
        int s = 0;
        for (int i = 0; i < 4 * rows; i++)
            s += (m_w[i] > m_t[i]) ? (m_w[i] - m_t[i]) : (m_t[i] - m_w[i]);
        return s;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) begin m_t[i] = 0; m_w[i] = 0; end
            m_rows = 0; m_addr = '0;
            e_busy = 0; e_done = 0; e_pruned = 0; e_valid = 0;
            e_sad = 0; e_min = 0; e_maddr = '0;
        end else begin
            e_done = 0;
            e_pruned = 0;
            if (!e_busy) begin
                if (Init) begin
                    for (int i = 0; i < 16; i++) m_t[i] = int'(v[i][PIX_W-1:0]);
                end else if (Start) begin
                    for (int i = 0; i < 16; i++) m_w[i] = int'(v[i][PIX_W-1:0]);
                    m_addr = Address;
                    m_rows = 0;
                    e_busy = 1;
                end
            end else begin
                m_rows++;
                m_part  = part_sum(m_rows);
                m_prune = EARLY && (m_rows < 4) && e_valid && (m_part >= e_min);
                if (m_rows == 4 || m_prune) begin
                    e_busy   = 0;
                    e_done   = 1;
                    e_pruned = m_prune;
                    e_sad    = m_part;
                    if (!m_prune && !ClearMin && (!e_valid || m_part < e_min)) begin
                        e_min   = m_part;
                        e_maddr = m_addr;
                        e_valid = 1;
                    end
                end
            end
            if (ClearMin) e_valid = 0;
        end
    end

    always @(negedge Clk) begin
        if (check_en) begin
            chk("busy", 32'(Busy), 32'(e_busy));
            chk("done", 32'(Done), 32'(e_done));
            if (e_done) chk("pruned", 32'(Pruned), 32'(e_pruned));
            chk("sad_value", 32'(SadValue), e_sad);
            chk("min_sad", 32'(MinSad), e_min);
            chk("min_address", MinAddress, e_maddr);
            chk("best_valid", 32'(BestValid), 32'(e_valid));
        end
    end

    task automatic set_all(input int val);
        for (int i = 0; i < 16; i++) v[i] = val;
    endtask

    task automatic do_init(input int val);
        set_all(val);
        Init = 1'b1;
        @(posedge Clk); #2;
        Init = 1'b0;
    endtask

    // Window must already be on v; it is scrambled afterwards to prove the snapshot.
    task automatic do_start(input logic [31:0] addr);
        Address = addr;
        Start = 1'b1;
        @(posedge Clk); #2;
        Start = 1'b0;
        for (int i = 0; i < 16; i++) v[i] = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge Clk); #1;
            lat++;
            if (Done) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL done_timeout: got no Done, expected Done within 20 cycles");
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(Busy), 0);
        chk({tag, "_done"}, 32'(Done), 0);
        chk({tag, "_pruned"}, 32'(Pruned), 0);
        chk({tag, "_sad"}, 32'(SadValue), 0);
        chk({tag, "_min"}, 32'(MinSad), 0);
        chk({tag, "_maddr"}, MinAddress, 0);
        chk({tag, "_valid"}, 32'(BestValid), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int prev;
        set_all(0);
        #1 Reset = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge Clk);
        #2 Reset = 1'b1;
        check_en = 1'b1;

        // Single window: T=10, W=13 -> 16*3
        do_init(10);
        set_all(13); do_start(32'h100); wait_done(lat);
        chk("single_latency", lat, 4);
        chk("single_sad", 32'(SadValue), 48);
        chk("single_min", 32'(MinSad), 48);
        chk("single_maddr", MinAddress, 32'h100);
        chk("single_valid", 32'(BestValid), 1);
        chk("single_pruned", 32'(Pruned), 0);
        prev = cyc;

        // Back-to-back start in the Done cycle; negative differences tie at 48
        set_all(7); do_start(32'h104); wait_done(lat);
        chk("b2b_gap", cyc - prev, 5);
        chk("tie_sad", 32'(SadValue), 48);
        chk("tie_maddr", MinAddress, 32'h100);

        // One pixel closer -> 45; Init/Start pulsed while busy are ignored
        set_all(13); v[0] = 10; do_start(32'h108);
        set_all(99); Init = 1'b1; Start = 1'b1; Address = 32'h300;
        @(posedge Clk); #2;
        Init = 1'b0; Start = 1'b0;
        wait_done(lat);
        chk("ignored_latency", lat, 3);
        chk("better_sad", 32'(SadValue), 45);
        chk("better_min", 32'(MinSad), 45);
        chk("better_maddr", MinAddress, 32'h108);
        @(posedge Clk); #2;

        // Init and Start together: only the template loads
        set_all(20); Init = 1'b1; Start = 1'b1; Address = 32'h400;
        @(posedge Clk); #2;
        Init = 1'b0; Start = 1'b0;
        chk("init_wins_busy", 32'(Busy), 0);
        set_all(20); do_start(32'h500); wait_done(lat);
        chk("new_tmpl_sad", 32'(SadValue), 0);
        chk("new_tmpl_maddr", MinAddress, 32'h500);
        @(posedge Clk); #2;

        do_init(10);
        ClearMin = 1'b1; @(posedge Clk); #2; ClearMin = 1'b0;
        chk("clear_idle_valid", 32'(BestValid), 0);

        // ClearMin coinciding with the Done edge
        set_all(11); do_start(32'h600);
        repeat (3) @(posedge Clk);
        #2 ClearMin = 1'b1;
        @(posedge Clk); #1;
        chk("clr_done", 32'(Done), 1);
        chk("clr_valid", 32'(BestValid), 0);
        chk("clr_sad", 32'(SadValue), 16);
        #1 ClearMin = 1'b0;
        @(posedge Clk); #2;

        // Min of 10, then a window whose row 0 alone already reaches 12
        set_all(10); for (int i = 0; i < 10; i++) v[i] = 11;
        do_start(32'h700); wait_done(lat);
        chk("min10_latency", lat, 4);
        chk("min10_min", 32'(MinSad), 10);
        @(posedge Clk); #2;
        set_all(10); for (int i = 0; i < 4; i++) v[i] = 13;
        do_start(32'h800); wait_done(lat);
        chk("prune_latency", lat, EARLY ? 1 : 4);
        chk("prune_flag", 32'(Pruned), 32'(EARLY));
        chk("prune_sad", 32'(SadValue), 12);
        chk("prune_min", 32'(MinSad), 10);
        chk("prune_maddr", MinAddress, 32'h700);
        @(posedge Clk); #2;

        // Asynchronous reset in the middle of an accumulation
        set_all(50); do_start(32'h900);
        @(posedge Clk); #3;
        Reset = 1'b0;
        #1 chk_all_zero("midreset");
        @(posedge Clk); #2;
        Reset = 1'b1;
        set_all(5); do_start(32'hA00); wait_done(lat);
        chk("post_reset_latency", lat, 4);
        chk("post_reset_sad", 32'(SadValue), 80);
        chk("post_reset_maddr", MinAddress, 32'hA00);
        @(posedge Clk); #2;

        // Randomized traffic; narrow pixel ranges provoke ties and pruning
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 16; i++)
                v[i] = (n % 2 == 0) ? (($urandom & 32'hFFFF_FF00) | 32'($urandom_range(8, 12)))
                                    : $urandom;
            Init     = ($urandom_range(0, 7) == 0);
            Start    = ($urandom_range(0, 1) == 1);
            ClearMin = ($urandom_range(0, 15) == 0);
            Address  = $urandom;
            @(posedge Clk); #2;
        end
        Init = 1'b0; Start = 1'b0; ClearMin = 1'b0;
        repeat (8) @(posedge Clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
